misex3_stim_sequencer: RTL and testbench

//  Upstream stimulus and response stage for the 14-in/14-out misex3 combinational core.

---
 rtl/misex3_stim_pkg.sv | 30 +++
 rtl/misex3_stim_sequencer_misr.sv | 36 +++
 rtl/misex3_stim_sequencer.sv | 113 +++++++++++
 tb/tb_misex3_stim_sequencer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/misex3_stim_pkg.sv
// Shared constants, state encoding and vector-step helper
// for the misex3 stimulus sequencer.
package misex3_stim_pkg;

    localparam int W     = 14;
    localparam int CNT_W = 15;

    localparam logic [W-1:0]     MISR_POLY = 14'h2803;
    localparam logic [W-1:0]     LFSR_TAPS = 14'h3802;
    localparam logic [W-1:0]     VEC_ONE   = 14'h0001;
    localparam logic [CNT_W-1:0] CNT_ONE   = 15'd1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    // Taps at bits 13,12,11,1 give the maximal-length 14-bit sequence
    function automatic logic [W-1:0] next_vec(
        input logic         lfsr,
        input logic [W-1:0] x
    );
        if (lfsr)
            return {x[W-2:0], ^(x & LFSR_TAPS)};
        return x + VEC_ONE;
    endfunction

endpackage

// File: rtl/misex3_stim_sequencer_misr.sv
// Multiple-input signature register compacting the
// captured core responses.
module misex3_misr
    import misex3_stim_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] sig
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr)
            sig_d = '0;
        else if (en)
            sig_d = {sig_q[W-2:0], 1'b0}
                  ^ (sig_q[W-1] ? MISR_POLY : '0)
                  ^ d;
    end

    always_ff @(posedge clk) begin
        if (rst)
            sig_q <= '0;
        else
            sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/misex3_stim_sequencer.sv
// Drives vectors into the misex3 core and streams each
// vector/response pair downstream while compacting responses.
module misex3_stim_sequencer
    import misex3_stim_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [W-1:0]     seed,
    input  logic [CNT_W-1:0] num_vec,
    output logic [W-1:0]     dut_x,
    input  logic [W-1:0]     dut_f,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [W-1:0]     resp_vec,
    output logic [W-1:0]     resp_f,
    output logic             busy,
    output logic             done,
    output logic [W-1:0]     signature
);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [W-1:0]     x_q, x_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             rv_q, rv_d;
    logic [W-1:0]     rvec_q, rvec_d;
    logic [W-1:0]     rf_q, rf_d;

    logic start_ok;
    logic advance;

    assign start_ok = start & ((state_q == IDLE) | (state_q == DONE));
    assign advance  = (state_q == RUN) & (~rv_q | resp_ready);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        rem_d   = rem_q;
        rv_d    = rv_q;
        rvec_d  = rvec_q;
        rf_d    = rf_q;
        if (start_ok) begin
            mode_d  = mode;
            x_d     = (mode && seed == '0) ? VEC_ONE : seed;
            rem_d   = num_vec;
            rv_d    = 1'b0;
            state_d = (num_vec == '0) ? DONE : RUN;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (advance) begin
                        rvec_d = x_q;
                        rf_d   = dut_f;
                        rv_d   = 1'b1;
                        rem_d  = rem_q - CNT_ONE;
                        // Last vector: hold dut_x and wait for the final accept
                        if (rem_q == CNT_ONE)
                            state_d = DRAIN;
                        else
                            x_d = next_vec(mode_q, x_q);
                    end
                end
                DRAIN: begin
                    if (rv_q && resp_ready) begin
                        rv_d    = 1'b0;
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            x_q     <= '0;
            rem_q   <= '0;
            rv_q    <= 1'b0;
            rvec_q  <= '0;
            rf_q    <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            rem_q   <= rem_d;
            rv_q    <= rv_d;
            rvec_q  <= rvec_d;
            rf_q    <= rf_d;
        end
    end

    misex3_misr u_misr (
        .clk (clk),
        .rst (rst),
        .clr (start_ok),
        .en  (advance),
        .d   (dut_f),
        .sig (signature)
    );

    assign dut_x      = x_q;
    assign resp_valid = rv_q;
    assign resp_vec   = rvec_q;
    assign resp_f     = rf_q;
    assign busy       = (state_q == RUN) | (state_q == DRAIN);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_misex3_stim_sequencer.sv
// Testbench for misex3_stim_sequencer with a stand-in core
// and a sequence/MISR reference model.
module tb_misex3_stim_sequencer;

    localparam logic [13:0] POLY = 14'h2803;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [13:0] seed;
    logic [14:0] num_vec;
    logic [13:0] dut_x;
    logic [13:0] dut_f;
    logic        resp_valid;
    logic        resp_ready;
    logic [13:0] resp_vec;
    logic [13:0] resp_f;
    logic        busy;
    logic        done;
    logic [13:0] signature;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] got_vec[$];
    logic [13:0] got_f[$];
    int          acc_cyc[$];
    logic [13:0] exp_vec[$];
    logic [13:0] exp_f[$];
    logic [13:0] exp_sig;
    int          done_cyc;
    int          run_timeout;
    int          freeze_err;
    int          stall_seen;
    int          valid_hi;

    always #5 clk = ~clk;

    misex3_stim_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .seed       (seed),
        .num_vec    (num_vec),
        .dut_x      (dut_x),
        .dut_f      (dut_f),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_vec   (resp_vec),
        .resp_f     (resp_f),
        .busy       (busy),
        .done       (done),
        .signature  (signature)
    );

    // Stand-in for the misex3 combinational core
    function automatic logic [13:0] core(input logic [13:0] x);
        logic [13:0] a;
        a = x ^ {x[6:0], x[13:7]};
        return (a + {x[2:0], x[13:3]}) ^ 14'h1A5C;
    endfunction

    assign dut_f = core(dut_x);

    task automatic build_model(input bit m, input logic [13:0] s, input int n);
        int x;
        int sg;
        int f;
        int fb;
        logic [13:0] xv;
        exp_vec.delete();
        exp_f.delete();
        sg = 0;
        x = (m && s == 0) ? 1 : int'(s);
        for (int i = 0; i < n; i++) begin
            xv = x[13:0];
            f  = int'(core(xv));
            exp_vec.push_back(xv);
            exp_f.push_back(f[13:0]);
            sg = ((sg * 2) % 16384) ^ ((sg >= 8192) ? int'(POLY) : 0) ^ f;
            if (m) begin
                fb = int'(xv[13] ^ xv[12] ^ xv[11] ^ xv[1]);
                x  = ((x * 2) % 16384) + fb;
            end else begin
                x = (x + 1) % 16384;
            end
        end
        exp_sig = sg[13:0];
    endtask

    function automatic int pair_errs();
        int e = 0;
        if (got_vec.size() != exp_vec.size())
            e++;
        for (int i = 0; i < got_vec.size() && i < exp_vec.size(); i++)
            if (got_vec[i] !== exp_vec[i] || got_f[i] !== exp_f[i])
                e++;
        return e;
    endfunction

    task automatic run_seq(input bit m, input logic [13:0] s, input int n,
                           input int ready_pct, input int stall_at,
                           input int stall_len);
        int          cyc;
        int          limit;
        bit          prev_stall;
        logic [56:0] snap;
        got_vec.delete();
        got_f.delete();
        acc_cyc.delete();
        done_cyc    = -1;
        run_timeout = 0;
        freeze_err  = 0;
        stall_seen  = 0;
        valid_hi    = 0;
        limit       = n * 8 + 50;
        @(negedge clk);
        mode       = m;
        seed       = s;
        num_vec    = n[14:0];
        start      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cyc        = 0;
        prev_stall = 1'b0;
        snap       = '0;
        while (1) begin
            if (prev_stall &&
                {resp_vec, resp_f, dut_x, signature, resp_valid} !== snap)
                freeze_err++;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc >= limit) begin
                run_timeout = 1;
                break;
            end
            if (cyc >= stall_at && cyc < stall_at + stall_len)
                resp_ready = 1'b0;
            else if (ready_pct >= 100)
                resp_ready = 1'b1;
            else
                resp_ready = ($urandom_range(99) < ready_pct);
            if (resp_valid)
                valid_hi++;
            if (resp_valid && resp_ready) begin
                got_vec.push_back(resp_vec);
                got_f.push_back(resp_f);
                acc_cyc.push_back(cyc);
            end
            prev_stall = resp_valid && !resp_ready;
            if (prev_stall && cyc >= stall_at && cyc < stall_at + stall_len)
                stall_seen++;
            snap = {resp_vec, resp_f, dut_x, signature, resp_valid};
            @(negedge clk);
            cyc++;
        end
        resp_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        seed = '0;
        num_vec = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({dut_x, resp_vec, resp_f, signature} !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %0h required 0",
                     {dut_x, resp_vec, resp_f, signature});
        end
        n_checks++;
        if ({resp_valid, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 000",
                     {resp_valid, busy, done});
        end
        rst = 1'b0;
    endtask

    task automatic test_counter();
        build_model(1'b0, 14'h0000, 4);
        run_seq(1'b0, 14'h0000, 4, 100, -1, 0);
        n_checks++;
        if (run_timeout !== 0) begin
            n_fail++;
            $display("FAIL counter_timeout: got timeout required done");
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_vec.size() <= i || got_vec[i] !== 14'(i) ||
                acc_cyc[i] !== i + 1) begin
                n_fail++;
                $display("FAIL counter_pair%0d: got %0h@%0d required %0h@%0d",
                         i, (got_vec.size() > i) ? got_vec[i] : 14'h0,
                         (acc_cyc.size() > i) ? acc_cyc[i] : -1, i, i + 1);
            end
        end
        n_checks++;
        if (done_cyc !== 5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL counter_done: got cyc %0d busy %b required 5 0",
                     done_cyc, busy);
        end
        n_checks++;
        if (signature !== exp_sig || pair_errs() !== 0) begin
            n_fail++;
            $display("FAIL counter_sig: got %0h required %0h", signature, exp_sig);
        end
    endtask

    task automatic test_wrap();
        run_seq(1'b0, 14'h3FFE, 3, 100, -1, 0);
        n_checks++;
        if (got_vec.size() != 3 || got_vec[0] !== 14'h3FFE ||
            got_vec[1] !== 14'h3FFF || got_vec[2] !== 14'h0000) begin
            n_fail++;
            $display("FAIL wrap: got %0d pairs, first %0h required 3FFE,3FFF,0",
                     got_vec.size(), (got_vec.size() > 0) ? got_vec[0] : 14'h0);
        end
    endtask

    task automatic test_lfsr();
        bit seen[16384];
        int dups;
        build_model(1'b1, 14'h0000, 16383);
        run_seq(1'b1, 14'h0000, 16383, 100, -1, 0);
        n_checks++;
        if (run_timeout !== 0 || got_vec.size() != 16383) begin
            n_fail++;
            $display("FAIL lfsr_count: got %0d pairs required 16383", got_vec.size());
        end
        n_checks++;
        if (got_vec.size() == 0 || got_vec[0] !== 14'h0001) begin
            n_fail++;
            $display("FAIL lfsr_first: got %0h required 1",
                     (got_vec.size() > 0) ? got_vec[0] : 14'h0);
        end
        dups = 0;
        foreach (got_vec[i]) begin
            if (got_vec[i] == 14'h0 || seen[got_vec[i]])
                dups++;
            seen[got_vec[i]] = 1'b1;
        end
        n_checks++;
        if (dups !== 0) begin
            n_fail++;
            $display("FAIL lfsr_unique: got %0d repeats required 0", dups);
        end
        n_checks++;
        if (pair_errs() !== 0 || signature !== exp_sig) begin
            n_fail++;
            $display("FAIL lfsr_model: got %0d errs sig %0h required 0 sig %0h",
                     pair_errs(), signature, exp_sig);
        end
    endtask

    task automatic test_backpressure();
        logic [13:0] s;
        s = 14'($urandom);
        build_model(1'b0, s, 12);
        run_seq(1'b0, s, 12, 100, 4, 3);
        n_checks++;
        if (stall_seen !== 3) begin
            n_fail++;
            $display("FAIL bp_stall: got %0d stall cycles required 3", stall_seen);
        end
        n_checks++;
        if (freeze_err !== 0) begin
            n_fail++;
            $display("FAIL bp_freeze: got %0d changes required 0", freeze_err);
        end
        n_checks++;
        if (pair_errs() !== 0 || signature !== exp_sig || run_timeout !== 0) begin
            n_fail++;
            $display("FAIL bp_scoreboard: got %0d errs sig %0h required 0 sig %0h",
                     pair_errs(), signature, exp_sig);
        end
    endtask

    task automatic test_random();
        bit          m;
        logic [13:0] s;
        int          n;
        for (int r = 0; r < 6; r++) begin
            m = 1'($urandom);
            s = 14'($urandom);
            n = $urandom_range(40, 1);
            build_model(m, s, n);
            run_seq(m, s, n, 60, -1, 0);
            n_checks++;
            if (pair_errs() !== 0 || signature !== exp_sig ||
                freeze_err !== 0 || run_timeout !== 0) begin
                n_fail++;
                $display("FAIL random%0d: got %0d errs sig %0h frz %0d required 0 sig %0h",
                         r, pair_errs(), signature, freeze_err, exp_sig);
            end
        end
    endtask

    task automatic test_zero();
        run_seq(1'b0, 14'h0123, 0, 100, -1, 0);
        n_checks++;
        if (done_cyc !== 0 || valid_hi !== 0 || got_vec.size() != 0) begin
            n_fail++;
            $display("FAIL zero_done: got cyc %0d valid %0d required 0 0",
                     done_cyc, valid_hi);
        end
        n_checks++;
        if (signature !== 14'h0) begin
            n_fail++;
            $display("FAIL zero_sig: got %0h required 0", signature);
        end
    endtask

    task automatic test_rst_midrun();
        logic [13:0] s;
        @(negedge clk);
        mode = 1'b0;
        seed = 14'h0040;
        num_vec = 15'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({dut_x, resp_vec, resp_f, signature, resp_valid, busy, done} !== 59'd0) begin
            n_fail++;
            $display("FAIL rst_midrun: got %0h required 0",
                     {dut_x, resp_vec, resp_f, signature, resp_valid, busy, done});
        end
        rst = 1'b0;
        s = 14'($urandom);
        build_model(1'b0, s, 16384);
        run_seq(1'b0, s, 16384, 75, -1, 0);
        n_checks++;
        if (pair_errs() !== 0 || signature !== exp_sig || run_timeout !== 0) begin
            n_fail++;
            $display("FAIL full_misr: got %0d errs sig %0h required 0 sig %0h",
                     pair_errs(), signature, exp_sig);
        end
    endtask

    initial begin
        test_reset();
        test_counter();
        test_wrap();
        test_backpressure();
        test_random();
        test_zero();
        test_lfsr();
        test_rst_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
